// File: rtl/uart_fifo_core.sv
// UART core with TX and RX FIFOs: queued bytes are framed and serialised on tx_out,
// and frames arriving on rx_in are deserialised, checked and queued with sticky error flags.

module uart_fifo_buf #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_reg;
    logic [AW:0]      rd_ptr_reg;
    logic             pop_ok;
    logic             push_ok;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign level   = wr_ptr_reg - rd_ptr_reg;
    assign empty   = (level == '0);
    assign full    = (level == DEPTH_L);
    assign pop_ok  = pop && !empty;
    // A push into a full buffer still lands when the head leaves in the same cycle.
    assign push_ok = push && (!full || pop_ok);
    assign rd_data = mem[rd_ptr_reg[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr_reg[AW-1:0]] <= wr_data;
    end
endmodule

module uart_fifo_core #(
    parameter int CLK_DIV    = 10416,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [DATA_BITS-1:0]            tx_data,
    input  logic                            tx_valid,
    output logic                            tx_ready,
    output logic                            tx_busy,
    output logic                            tx_out,
    input  logic                            rx_in,
    output logic [DATA_BITS-1:0]            rx_data,
    output logic                            rx_valid,
    input  logic                            rx_pop,
    input  logic                            err_clear,
    output logic                            rx_ore,
    output logic                            rx_fe,
    output logic                            rx_pe,
    output logic [$clog2(FIFO_DEPTH):0]     tx_level,
    output logic [$clog2(FIFO_DEPTH):0]     rx_level
);
    localparam logic [15:0] BAUD_LAST = 16'(CLK_DIV - 1);
    localparam logic [15:0] HALF_LAST = 16'(CLK_DIV / 2 - 1);
    localparam logic [2:0]  BIT_LAST  = 3'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    // ---------------- TX path ----------------
    logic                 tx_full;
    logic                 tx_empty;
    logic                 tx_pop;
    logic [DATA_BITS-1:0] tx_head;

    state_t               tx_state_reg, tx_state_next;
    logic [15:0]          tx_baud_reg, tx_baud_next;
    logic [2:0]           tx_bit_reg, tx_bit_next;
    logic [DATA_BITS-1:0] tx_shift_reg, tx_shift_next;
    logic                 tx_par_reg, tx_par_next;
    logic                 tx_out_reg, tx_out_next;

    uart_fifo_buf #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (tx_valid && !tx_full),
        .pop     (tx_pop),
        .wr_data (tx_data),
        .rd_data (tx_head),
        .full    (tx_full),
        .empty   (tx_empty),
        .level   (tx_level)
    );

    assign tx_ready = !tx_full;
    assign tx_busy  = !tx_empty || (tx_state_reg != S_IDLE);
    assign tx_out   = tx_out_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_reg <= S_IDLE;
            tx_baud_reg  <= '0;
            tx_bit_reg   <= '0;
            tx_shift_reg <= '0;
            tx_par_reg   <= 1'b0;
            tx_out_reg   <= 1'b1;
        end else begin
            tx_state_reg <= tx_state_next;
            tx_baud_reg  <= tx_baud_next;
            tx_bit_reg   <= tx_bit_next;
            tx_shift_reg <= tx_shift_next;
            tx_par_reg   <= tx_par_next;
            tx_out_reg   <= tx_out_next;
        end
    end

    // tx_out is registered and set on each transition, so it changes exactly at bit boundaries.
    always_comb begin
        tx_state_next = tx_state_reg;
        tx_baud_next  = tx_baud_reg;
        tx_bit_next   = tx_bit_reg;
        tx_shift_next = tx_shift_reg;
        tx_par_next   = tx_par_reg;
        tx_out_next   = tx_out_reg;
        tx_pop        = 1'b0;

        if (tx_state_reg != S_IDLE) begin
            tx_baud_next = (tx_baud_reg == BAUD_LAST) ? 16'd0 : tx_baud_reg + 16'd1;
        end

        case (tx_state_reg)
            S_IDLE: begin
                if (!tx_empty) begin
                    tx_pop        = 1'b1;
                    tx_shift_next = tx_head;
                    tx_par_next   = (PARITY == 1) ? ~^tx_head : ^tx_head;
                    tx_baud_next  = '0;
                    tx_out_next   = 1'b0;
                    tx_state_next = S_START;
                end
            end
            S_START: begin
                if (tx_baud_reg == BAUD_LAST) begin
                    tx_bit_next   = '0;
                    tx_out_next   = tx_shift_reg[0];
                    tx_state_next = S_DATA;
                end
            end
            S_DATA: begin
                if (tx_baud_reg == BAUD_LAST) begin
                    if (tx_bit_reg == BIT_LAST) begin
                        if (PARITY != 0) begin
                            tx_out_next   = tx_par_reg;
                            tx_state_next = S_PARITY;
                        end else begin
                            tx_out_next   = 1'b1;
                            tx_state_next = S_STOP;
                        end
                    end else begin
                        tx_bit_next   = tx_bit_reg + 3'd1;
                        tx_shift_next = tx_shift_reg >> 1;
                        tx_out_next   = tx_shift_reg[1];
                    end
                end
            end
            S_PARITY: begin
                if (tx_baud_reg == BAUD_LAST) begin
                    tx_out_next   = 1'b1;
                    tx_state_next = S_STOP;
                end
            end
            S_STOP: begin
                if (tx_baud_reg == BAUD_LAST) begin
                    if (!tx_empty) begin
                        tx_pop        = 1'b1;
                        tx_shift_next = tx_head;
                        tx_par_next   = (PARITY == 1) ? ~^tx_head : ^tx_head;
                        tx_out_next   = 1'b0;
                        tx_state_next = S_START;
                    end else begin
                        tx_out_next   = 1'b1;
                        tx_state_next = S_IDLE;
                    end
                end
            end
            default: begin
                tx_out_next   = 1'b1;
                tx_state_next = S_IDLE;
            end
        endcase
    end

    // ---------------- RX path ----------------
    logic [1:0]           rx_sync_reg;
    logic                 rx_prev_reg;
    logic                 rx_s;
    logic                 rx_full;
    logic                 rx_empty;
    logic                 rx_push;
    logic                 parity_bad;
    logic                 fe_set;
    logic                 pe_set;
    logic                 ore_set;

    state_t               rx_state_reg, rx_state_next;
    logic [15:0]          rx_baud_reg, rx_baud_next;
    logic [2:0]           rx_bit_reg, rx_bit_next;
    logic [DATA_BITS-1:0] rx_shift_reg, rx_shift_next;
    logic                 rx_par_reg, rx_par_next;
    logic                 rx_ore_reg, rx_fe_reg, rx_pe_reg;

    uart_fifo_buf #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (rx_push),
        .pop     (rx_pop),
        .wr_data (rx_shift_reg),
        .rd_data (rx_data),
        .full    (rx_full),
        .empty   (rx_empty),
        .level   (rx_level)
    );

    assign rx_valid = !rx_empty;
    assign rx_s     = rx_sync_reg[1];
    assign rx_ore   = rx_ore_reg;
    assign rx_fe    = rx_fe_reg;
    assign rx_pe    = rx_pe_reg;

    always_comb begin
        parity_bad = 1'b0;
        if (PARITY == 1)      parity_bad = ~(^rx_shift_reg ^ rx_par_reg);
        else if (PARITY == 2) parity_bad = ^rx_shift_reg ^ rx_par_reg;
    end

    // Overrun only when the head is not leaving in the same cycle.
    assign ore_set = rx_push && rx_full && !(rx_pop && rx_valid);

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_sync_reg  <= 2'b11;
            rx_prev_reg  <= 1'b1;
            rx_state_reg <= S_IDLE;
            rx_baud_reg  <= '0;
            rx_bit_reg   <= '0;
            rx_shift_reg <= '0;
            rx_par_reg   <= 1'b0;
            rx_ore_reg   <= 1'b0;
            rx_fe_reg    <= 1'b0;
            rx_pe_reg    <= 1'b0;
        end else begin
            rx_sync_reg  <= {rx_sync_reg[0], rx_in};
            rx_prev_reg  <= rx_s;
            rx_state_reg <= rx_state_next;
            rx_baud_reg  <= rx_baud_next;
            rx_bit_reg   <= rx_bit_next;
            rx_shift_reg <= rx_shift_next;
            rx_par_reg   <= rx_par_next;
            rx_ore_reg   <= (rx_ore_reg && !err_clear) || ore_set;
            rx_fe_reg    <= (rx_fe_reg && !err_clear) || fe_set;
            rx_pe_reg    <= (rx_pe_reg && !err_clear) || pe_set;
        end
    end

    always_comb begin
        rx_state_next = rx_state_reg;
        rx_baud_next  = rx_baud_reg;
        rx_bit_next   = rx_bit_reg;
        rx_shift_next = rx_shift_reg;
        rx_par_next   = rx_par_reg;
        rx_push       = 1'b0;
        fe_set        = 1'b0;
        pe_set        = 1'b0;

        if (rx_state_reg != S_IDLE) begin
            rx_baud_next = rx_baud_reg + 16'd1;
        end

        case (rx_state_reg)
            S_IDLE: begin
                if (rx_prev_reg && !rx_s) begin
                    rx_baud_next  = '0;
                    rx_state_next = S_START;
                end
            end
            S_START: begin
                if (rx_baud_reg == HALF_LAST) begin
                    rx_baud_next  = '0;
                    rx_bit_next   = '0;
                    rx_state_next = rx_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (rx_baud_reg == BAUD_LAST) begin
                    rx_baud_next  = '0;
                    rx_shift_next = {rx_s, rx_shift_reg[DATA_BITS-1:1]};
                    if (rx_bit_reg == BIT_LAST) begin
                        rx_state_next = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        rx_bit_next = rx_bit_reg + 3'd1;
                    end
                end
            end
            S_PARITY: begin
                if (rx_baud_reg == BAUD_LAST) begin
                    rx_baud_next  = '0;
                    rx_par_next   = rx_s;
                    rx_state_next = S_STOP;
                end
            end
            S_STOP: begin
                if (rx_baud_reg == BAUD_LAST) begin
                    rx_baud_next  = '0;
                    fe_set        = !rx_s;
                    pe_set        = parity_bad;
                    rx_push       = rx_s && !parity_bad;
                    rx_state_next = S_IDLE;
                end
            end
            default: rx_state_next = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_uart_fifo_core.sv
// Directed bench: instance "a" (no parity) for TX/RX framing and FIFO boundaries,
// instance "p" (even parity) with tx_out looped back to rx_in.
`timescale 1ns/1ps
module tb_uart_fifo_core;
    localparam int LW = 5;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [7:0]    a_tx_data, a_rx_data, p_tx_data, p_rx_data;
    logic          a_tx_valid, a_tx_ready, a_tx_busy, a_tx_out, a_rx_in, a_rx_valid, a_rx_pop;
    logic          a_err_clear, a_rx_ore, a_rx_fe, a_rx_pe;
    logic [LW-1:0] a_tx_level, a_rx_level, p_tx_level, p_rx_level;
    logic          p_tx_valid, p_tx_ready, p_tx_busy, p_tx_out, p_rx_valid, p_rx_pop;
    logic          p_err_clear, p_rx_ore, p_rx_fe, p_rx_pe;

    int checks = 0;
    int errors = 0;
    logic [7:0] burst [17];
    logic [7:0] rxb [17];

    uart_fifo_core #(.CLK_DIV(16), .DATA_BITS(8), .PARITY(0), .FIFO_DEPTH(16)) u_dut (
        .clk(clk), .rst(rst), .tx_data(a_tx_data), .tx_valid(a_tx_valid), .tx_ready(a_tx_ready),
        .tx_busy(a_tx_busy), .tx_out(a_tx_out), .rx_in(a_rx_in), .rx_data(a_rx_data),
        .rx_valid(a_rx_valid), .rx_pop(a_rx_pop), .err_clear(a_err_clear), .rx_ore(a_rx_ore),
        .rx_fe(a_rx_fe), .rx_pe(a_rx_pe), .tx_level(a_tx_level), .rx_level(a_rx_level)
    );

    uart_fifo_core #(.CLK_DIV(16), .DATA_BITS(8), .PARITY(2), .FIFO_DEPTH(16)) u_par (
        .clk(clk), .rst(rst), .tx_data(p_tx_data), .tx_valid(p_tx_valid), .tx_ready(p_tx_ready),
        .tx_busy(p_tx_busy), .tx_out(p_tx_out), .rx_in(p_tx_out), .rx_data(p_rx_data),
        .rx_valid(p_rx_valid), .rx_pop(p_rx_pop), .err_clear(p_err_clear), .rx_ore(p_rx_ore),
        .rx_fe(p_rx_fe), .rx_pe(p_rx_pe), .tx_level(p_tx_level), .rx_level(p_rx_level)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    // Entered just after the edge that starts a frame; returns just after its last stop cycle.
    task automatic check_frame(input logic [7:0] d);
        logic [9:0] bits;
        bits = {1'b1, d, 1'b0};
        check("tx_start_edge", a_tx_out, 0);
        for (int b = 0; b < 10; b++) begin
            repeat (8) tick();
            check($sformatf("tx_bit%0d_of_%02h", b, d), a_tx_out, bits[b]);
            repeat (7) tick();
            if (b == 9) begin
                check("tx_stop_end", a_tx_out, 1);
                check("tx_busy_in_stop", a_tx_busy, 1);
            end
            tick();
        end
    endtask

    task automatic send_rx(input logic [7:0] d, input logic stop);
        logic [9:0] bits;
        bits = {stop, d, 1'b0};
        for (int b = 0; b < 10; b++) begin
            a_rx_in = bits[b];
            repeat (16) tick();
        end
        a_rx_in = 1'b1;
    endtask

    task automatic loop_byte(input logic [7:0] d);
        p_tx_data  = d;
        p_tx_valid = 1'b1;
        tick();
        p_tx_valid = 1'b0;
        for (int k = 0; k < 400; k++) begin
            if (p_rx_valid) break;
            tick();
        end
        check("lb_valid", p_rx_valid, 1);
        check("lb_data", p_rx_data, d);
        check("lb_level", p_rx_level, 1);
        check("lb_pe", p_rx_pe, 0);
        check("lb_fe", p_rx_fe, 0);
        p_rx_pop = 1'b1;
        tick();
        p_rx_pop = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 17; i++) begin
            burst[i] = 8'(i * 37 + 5);
            rxb[i]   = 8'(i * 29 + 3);
        end
        rst = 1'b1;
        a_tx_data = '0; a_tx_valid = 0; a_rx_in = 1; a_rx_pop = 0; a_err_clear = 0;
        p_tx_data = '0; p_tx_valid = 0; p_rx_pop = 0; p_err_clear = 0;
        repeat (3) tick();
        check("rst_tx_out", a_tx_out, 1);
        check("rst_tx_busy", a_tx_busy, 0);
        check("rst_tx_ready", a_tx_ready, 1);
        check("rst_rx_valid", a_rx_valid, 0);
        check("rst_tx_level", a_tx_level, 0);
        check("rst_rx_level", a_rx_level, 0);
        check("rst_flags", {a_rx_ore, a_rx_fe, a_rx_pe}, 0);
        rst = 1'b0;
        tick();

        // Single frame 0xA5 with one-cycle start latency
        a_tx_data  = 8'hA5;
        a_tx_valid = 1'b1;
        tick();
        a_tx_valid = 1'b0;
        check("a5_still_idle", a_tx_out, 1);
        check("a5_busy", a_tx_busy, 1);
        check("a5_level", a_tx_level, 1);
        tick();
        check_frame(8'hA5);
        check("a5_busy_after", a_tx_busy, 0);
        check("a5_idle_high", a_tx_out, 1);

        // Burst of 17 writes plus one while full; first four frames back-to-back
        fork
            begin
                for (int i = 0; i < 18; i++) begin
                    a_tx_valid = 1'b1;
                    a_tx_data  = (i < 17) ? burst[i] : 8'hFF;
                    tick();
                    if (i == 15) begin
                        check("burst_lvl15", a_tx_level, 15);
                        check("burst_ready15", a_tx_ready, 1);
                    end
                    if (i == 16) begin
                        check("burst_lvl16", a_tx_level, 16);
                        check("burst_ready16", a_tx_ready, 0);
                    end
                    if (i == 17) check("burst_full_ignored", a_tx_level, 16);
                end
                a_tx_valid = 1'b0;
            end
            begin
                tick();
                tick();
                for (int k = 0; k < 4; k++) check_frame(burst[k]);
            end
        join

        // Reset in the middle of frame 5
        repeat (40) tick();
        rst = 1'b1;
        tick();
        check("txrst_out", a_tx_out, 1);
        check("txrst_level", a_tx_level, 0);
        check("txrst_busy", a_tx_busy, 0);
        check("txrst_ready", a_tx_ready, 1);
        rst = 1'b0;
        tick();
        check("txrst_out_after", a_tx_out, 1);

        // RX: good frame, pop, pop on empty
        send_rx(8'h96, 1'b1);
        repeat (2) tick();
        check("rx_valid", a_rx_valid, 1);
        check("rx_data", a_rx_data, 8'h96);
        check("rx_level1", a_rx_level, 1);
        check("rx_fe_clean", a_rx_fe, 0);
        a_rx_pop = 1'b1;
        tick();
        check("rx_pop_level", a_rx_level, 0);
        check("rx_pop_valid", a_rx_valid, 0);
        tick();
        a_rx_pop = 1'b0;
        check("rx_pop_empty", a_rx_level, 0);

        // Framing error then clear
        send_rx(8'h55, 1'b0);
        repeat (2) tick();
        check("fe_set", a_rx_fe, 1);
        check("fe_level", a_rx_level, 0);
        a_err_clear = 1'b1;
        tick();
        a_err_clear = 1'b0;
        check("fe_cleared", a_rx_fe, 0);

        // Overrun: 17 frames into a 16-deep FIFO
        for (int i = 0; i < 17; i++) send_rx(rxb[i], 1'b1);
        repeat (2) tick();
        check("ore_level", a_rx_level, 16);
        check("ore_flag", a_rx_ore, 1);
        check("ore_head", a_rx_data, rxb[0]);
        a_rx_pop = 1'b1;
        tick();
        a_rx_pop = 1'b0;
        check("ore_pop_head", a_rx_data, rxb[1]);
        check("ore_pop_level", a_rx_level, 15);

        // Reset in the middle of an RX frame
        a_rx_in = 1'b0;
        repeat (16) tick();
        a_rx_in = 1'b1;
        repeat (16) tick();
        a_rx_in = 1'b0;
        repeat (10) tick();
        rst = 1'b1;
        tick();
        check("rxrst_level", a_rx_level, 0);
        check("rxrst_valid", a_rx_valid, 0);
        check("rxrst_ore", a_rx_ore, 0);
        rst = 1'b0;
        a_rx_in = 1'b1;
        repeat (300) tick();
        check("rxrst_no_push", a_rx_valid, 0);
        check("rxrst_no_fe", a_rx_fe, 0);

        // Even-parity loopback
        loop_byte(8'h3C);
        loop_byte(8'h01);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
